dnn_mac_engine_param: RTL and testbench

// - Parametrised, time-multiplexed 2-layer GNN/DNN inference engine: layer-1 MAC + ReLU,

---
 rtl/dnn_mac_engine_param_if.sv | 37 +++
 rtl/dnn_mac_engine_param.sv | 194 +++++++++++++++++++
 tb/tb_dnn_mac_engine_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_mac_engine_param_if.sv
// Handshake/data bundle linking the MAC engine to the feature loader, the
// neighbour aggregation unit and the result collector.
interface dnn_mac_engine_param_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_HID = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned XW    = 7,
  parameter int unsigned WW    = 5,
  parameter int unsigned HW    = 15,
  parameter int unsigned AW    = 17,
  parameter int unsigned OW    = 21
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*XW-1:0]        x_flat;
  logic [N_IN*N_HID*WW-1:0]  w1_flat;
  logic [N_HID*N_OUT*WW-1:0] w2_flat;
  logic                      hid_valid;
  logic [N_HID*HW-1:0]       hid_relu;
  logic                      aggr_valid;
  logic [N_HID*AW-1:0]       aggr_flat;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_OUT*OW-1:0]       out_flat;

  // Driver side: loader, aggregator and collector.
  modport master (
    output in_valid, x_flat, w1_flat, w2_flat, aggr_valid, aggr_flat, out_ready,
    input  in_ready, hid_valid, hid_relu, out_valid, out_flat
  );

  // Engine side.
  modport slave (
    input  in_valid, x_flat, w1_flat, w2_flat, aggr_valid, aggr_flat, out_ready,
    output in_ready, hid_valid, hid_relu, out_valid, out_flat
  );
endinterface

// File: rtl/dnn_mac_engine_param.sv
// Time-multiplexed 2-layer inference engine: layer-1 MAC + ReLU, external aggregation
// handshake, output-layer MAC. Macro DNN_OUT_SAT_EN selects saturating outputs (else wrap).
module dnn_mac_engine_param #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_HID = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned LANES = 2,
  parameter int unsigned XW    = 7,
  parameter int unsigned WW    = 5,
  parameter int unsigned HW    = 15,
  parameter int unsigned AW    = 17,
  parameter int unsigned OW    = 21
) (
  input logic clk,
  input logic rst,
  dnn_mac_engine_param_if.slave bus
);
  localparam int unsigned M    = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned OPW  = (XW > AW) ? XW : AW;
  localparam int unsigned PW   = OPW + WW;
  localparam int unsigned SW   = PW + $clog2(N_HID + 1);
  localparam int unsigned S1   = (N_HID + LANES - 1) / LANES;
  localparam int unsigned S2   = (N_OUT + LANES - 1) / LANES;
  localparam int unsigned SMAX = (S1 > S2) ? S1 : S2;
  localparam int unsigned CW   = $clog2(SMAX + 1);

  typedef enum logic [2:0] {IDLE, L1, HID, L2, OUT} state_t;

  state_t state, state_nxt;
  logic   step_done_c;
  logic   sum_en_c;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sum_step_c;

  logic signed [XW-1:0]  x_q    [N_IN];
  logic signed [WW-1:0]  w1_q   [N_HID][N_IN];
  logic signed [WW-1:0]  w2_q   [N_OUT][N_HID];
  logic signed [AW-1:0]  aggr_q [N_HID];
  logic signed [OPW-1:0] opa_c  [LANES][M];
  logic signed [WW-1:0]  opb_c  [LANES][M];
  logic signed [PW-1:0]  prod_q [LANES][M];
  logic signed [HW-1:0]  l1_sum_c [LANES];
  logic signed [SW-1:0]  l2_sum_c [LANES];

  function automatic logic [HW-1:0] relu(input logic signed [HW-1:0] s);
    return s[HW-1] ? '0 : s;
  endfunction

`ifdef DNN_OUT_SAT_EN
  localparam logic signed [SW-1:0] OMAX = (SW'(1) <<< (OW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] OMIN = -(SW'(1) <<< (OW - 1));

  function automatic logic [OW-1:0] reduce_out(input logic signed [SW-1:0] s);
    if (s > OMAX) return OW'(OMAX);
    if (s < OMIN) return OW'(OMIN);
    return OW'(s);
  endfunction
`else
  function automatic logic [OW-1:0] reduce_out(input logic signed [SW-1:0] s);
    return OW'(s);
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a step phase ends after its last partial sum is folded in.
  always_comb begin
    state_nxt   = state;
    step_done_c = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = L1;
      L1: if (cnt == CW'(S1)) begin
        state_nxt   = HID;
        step_done_c = 1'b1;
      end
      HID: if (bus.aggr_valid) state_nxt = L2;
      L2: if (cnt == CW'(S2)) begin
        state_nxt   = OUT;
        step_done_c = 1'b1;
      end
      OUT: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Products registered at step cnt are summed while cnt+1 is being multiplied.
  assign sum_en_c   = ((state == L1) || (state == L2)) && (cnt != '0);
  assign sum_step_c = cnt - CW'(1);

  // Registered handshake outputs and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready  <= 1'b1;
      bus.hid_valid <= 1'b0;
      bus.out_valid <= 1'b0;
      cnt           <= '0;
    end else begin
      bus.in_ready  <= (state_nxt == IDLE);
      bus.hid_valid <= (state_nxt == HID);
      bus.out_valid <= (state_nxt == OUT);
      if (((state == L1) || (state == L2)) && !step_done_c) cnt <= cnt + CW'(1);
      else                                                  cnt <= '0;
    end
  end

  // Operand capture: sample vectors on accept, aggregated vector on aggregation handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      for (int h = 0; h < N_HID; h++) begin
        aggr_q[h] <= '0;
        for (int i = 0; i < N_IN; i++) w1_q[h][i] <= '0;
      end
      for (int o = 0; o < N_OUT; o++)
        for (int h = 0; h < N_HID; h++) w2_q[o][h] <= '0;
    end else begin
      if ((state == IDLE) && bus.in_valid) begin
        for (int i = 0; i < N_IN; i++) x_q[i] <= bus.x_flat[i*XW +: XW];
        for (int h = 0; h < N_HID; h++)
          for (int i = 0; i < N_IN; i++) w1_q[h][i] <= bus.w1_flat[(h*N_IN+i)*WW +: WW];
        for (int o = 0; o < N_OUT; o++)
          for (int h = 0; h < N_HID; h++) w2_q[o][h] <= bus.w2_flat[(o*N_HID+h)*WW +: WW];
      end
      if ((state == HID) && bus.aggr_valid)
        for (int h = 0; h < N_HID; h++) aggr_q[h] <= bus.aggr_flat[h*AW +: AW];
    end
  end

  // Lane operand routing: neuron n = cnt*LANES + j lives on lane n % LANES.
  always_comb begin
    for (int j = 0; j < LANES; j++)
      for (int m = 0; m < M; m++) begin
        opa_c[j][m] = '0;
        opb_c[j][m] = '0;
      end
    if (state == L2) begin
      for (int o = 0; o < N_OUT; o++)
        if (cnt == CW'(o / LANES))
          for (int h = 0; h < N_HID; h++) begin
            opa_c[o % LANES][h] = OPW'(aggr_q[h]);
            opb_c[o % LANES][h] = w2_q[o][h];
          end
    end else begin
      for (int h = 0; h < N_HID; h++)
        if (cnt == CW'(h / LANES))
          for (int i = 0; i < N_IN; i++) begin
            opa_c[h % LANES][i] = OPW'(x_q[i]);
            opb_c[h % LANES][i] = w1_q[h][i];
          end
    end
  end

  // Shared multiplier bank, full-precision signed products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LANES; j++)
        for (int m = 0; m < M; m++) prod_q[j][m] <= '0;
    end else begin
      for (int j = 0; j < LANES; j++)
        for (int m = 0; m < M; m++) prod_q[j][m] <= PW'(opa_c[j][m]) * PW'(opb_c[j][m]);
    end
  end

  // Per-lane adder trees: layer 1 wraps to HW, layer 2 keeps full width.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      l1_sum_c[j] = '0;
      l2_sum_c[j] = '0;
      for (int m = 0; m < M; m++) begin
        l1_sum_c[j] = l1_sum_c[j] + HW'(prod_q[j][m]);
        l2_sum_c[j] = l2_sum_c[j] + SW'(prod_q[j][m]);
      end
    end
  end

  // Result write-back; lanes mapped past the last neuron are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hid_relu <= '0;
      bus.out_flat <= '0;
    end else begin
      if (sum_en_c && (state == L1))
        for (int h = 0; h < N_HID; h++)
          if (sum_step_c == CW'(h / LANES)) bus.hid_relu[h*HW +: HW] <= relu(l1_sum_c[h % LANES]);
      if (sum_en_c && (state == L2))
        for (int o = 0; o < N_OUT; o++)
          if (sum_step_c == CW'(o / LANES)) bus.out_flat[o*OW +: OW] <= reduce_out(l2_sum_c[o % LANES]);
    end
  end
endmodule

// File: tb/tb_dnn_mac_engine_param.sv
// Bench for dnn_mac_engine_param: directed cases plus randomized samples against an
// arithmetic reference model with a per-cycle compare process.
module tb_dnn_mac_engine_param;
  localparam int unsigned N_IN = 4, N_HID = 4, N_OUT = 2, LANES = 2;
  localparam int unsigned XW = 7, WW = 5, HW = 15, AW = 17, OW = 21;
  localparam int unsigned S1 = (N_HID + LANES - 1) / LANES;
  localparam int unsigned S2 = (N_OUT + LANES - 1) / LANES;
  localparam int unsigned XF = N_IN*XW, W1F = N_IN*N_HID*WW, W2F = N_HID*N_OUT*WW;
  localparam int unsigned HF = N_HID*HW, AF = N_HID*AW, OF = N_OUT*OW;
  localparam int BOUND = 200;
  localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dnn_mac_engine_param_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .XW(XW), .WW(WW),
                            .HW(HW), .AW(AW), .OW(OW)) bus ();

  dnn_mac_engine_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .LANES(LANES), .XW(XW),
                         .WW(WW), .HW(HW), .AW(AW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: hidden[h] = sum_i x[i]*w1[i][h], wrapped to HW bits, then ReLU.
  function automatic logic [HF-1:0] model_hid(input logic [XF-1:0] x, input logic [W1F-1:0] w1);
    logic [HF-1:0] r;
    longint s;
    logic [HW-1:0] t;
    r = '0;
    for (int h = 0; h < N_HID; h++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'($signed(x[i*XW +: XW])) * longint'($signed(w1[(h*N_IN+i)*WW +: WW]));
      t = s[HW-1:0];
      r[h*HW +: HW] = t[HW-1] ? '0 : t;
    end
    return r;
  endfunction

  // Reference: out[o] = sum_h aggr[h]*w2[h][o], saturated or wrapped to OW bits.
  function automatic logic [OF-1:0] model_out(input logic [AF-1:0] a, input logic [W2F-1:0] w2);
    logic [OF-1:0] r;
    longint s;
    r = '0;
    for (int o = 0; o < N_OUT; o++) begin
      s = 0;
      for (int h = 0; h < N_HID; h++)
        s += longint'($signed(a[h*AW +: AW])) * longint'($signed(w2[(o*N_HID+h)*WW +: WW]));
`ifdef DNN_OUT_SAT_EN
      if (s > OMAX) s = OMAX;
      else if (s < OMIN) s = OMIN;
`endif
      r[o*OW +: OW] = s[OW-1:0];
    end
    return r;
  endfunction

  // Expected DUT-visible state after each edge; t1/t2 count edges until a result appears.
  logic          e_in_ready, e_hid_valid, e_out_valid;
  logic [HF-1:0] e_hid;
  logic [OF-1:0] e_out;
  logic [W2F-1:0] e_w2;
  int t1 = 0, t2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      e_in_ready = 1'b1; e_hid_valid = 1'b0; e_out_valid = 1'b0;
      e_hid = '0; e_out = '0; t1 = 0; t2 = 0;
    end
    chk("in_ready", 128'(bus.in_ready), 128'(e_in_ready));
    chk("hid_valid", 128'(bus.hid_valid), 128'(e_hid_valid));
    chk("out_valid", 128'(bus.out_valid), 128'(e_out_valid));
    if (t1 == 0) chk("hid_relu", 128'(bus.hid_relu), 128'(e_hid));
    if (t2 == 0) chk("out_flat", 128'(bus.out_flat), 128'(e_out));
    if (!rst) begin
      if (t1 != 0) begin
        t1--;
        if (t1 == 0) e_hid_valid = 1'b1;
      end else if (t2 != 0) begin
        t2--;
        if (t2 == 0) e_out_valid = 1'b1;
      end else if (e_in_ready && bus.in_valid) begin
        e_in_ready = 1'b0;
        t1 = S1 + 1;
        e_hid = model_hid(bus.x_flat, bus.w1_flat);
        e_w2 = bus.w2_flat;
      end else if (e_hid_valid && bus.aggr_valid) begin
        e_hid_valid = 1'b0;
        t2 = S2 + 1;
        e_out = model_out(bus.aggr_flat, e_w2);
      end else if (e_out_valid && bus.out_ready) begin
        e_out_valid = 1'b0;
        e_in_ready = 1'b1;
      end
    end
  end

  function automatic logic [XF-1:0] fill_x(input int v);
    logic [XF-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*XW +: XW] = XW'(v);
    return r;
  endfunction
  function automatic logic [W1F-1:0] fill_w1(input int v);
    logic [W1F-1:0] r;
    for (int i = 0; i < N_IN*N_HID; i++) r[i*WW +: WW] = WW'(v);
    return r;
  endfunction
  function automatic logic [W2F-1:0] fill_w2(input int v);
    logic [W2F-1:0] r;
    for (int i = 0; i < N_HID*N_OUT; i++) r[i*WW +: WW] = WW'(v);
    return r;
  endfunction
  function automatic logic [AF-1:0] fill_a(input int v);
    logic [AF-1:0] r;
    for (int h = 0; h < N_HID; h++) r[h*AW +: AW] = AW'(v);
    return r;
  endfunction
  function automatic logic [AF-1:0] rand_aggr();
    logic [AF-1:0] r;
    if ($urandom_range(0, 1) == 0) r = AF'(rnd128());
    else for (int h = 0; h < N_HID; h++) r[h*AW +: AW] = AW'(int'($urandom_range(0, 400)) - 200);
    return r;
  endfunction

  // Present a sample, wait for acceptance, then wait for hid_valid while jiggling aggr_valid.
  task automatic send(input logic [XF-1:0] x, input logic [W1F-1:0] w1,
                      input logic [W2F-1:0] w2, output int lat);
    bit ok;
    bus.x_flat = x; bus.w1_flat = w1; bus.w2_flat = w2; bus.in_valid = 1'b1;
    ok = 1'b0;
    lat = 0;
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_flat = XF'(rnd128()); bus.w1_flat = W1F'(rnd128()); bus.w2_flat = W2F'(rnd128());
    while (!bus.hid_valid && lat < BOUND) begin
      bus.aggr_valid = 1'($urandom_range(0, 1));
      bus.aggr_flat = AF'(rnd128());
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.hid_valid) chk("hid_timeout", 128'(0), 128'(1));
  endtask

  task automatic drive_aggr(input logic [AF-1:0] a, input int delay);
    bus.aggr_valid = 1'b0;
    for (int d = 0; d < delay; d++) begin @(posedge clk); #1; end
    bus.aggr_valid = 1'b1; bus.aggr_flat = a;
    @(posedge clk); #1;
    bus.aggr_valid = 1'b0; bus.aggr_flat = AF'(rnd128());
  endtask

  task automatic wait_out(input bit early, output int lat);
    bus.out_ready = early;
    lat = 0;
    while (!bus.out_valid && lat < BOUND) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) chk("out_timeout", 128'(0), 128'(1));
  endtask

  task automatic release_out(input int hold);
    for (int c = 0; c < hold; c++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x_flat = XF'(rnd128());
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.aggr_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x_flat = '0; bus.w1_flat = '0; bus.w2_flat = '0; bus.aggr_flat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset_out_flat", 128'(bus.out_flat), 128'(0));

    // All-ones layer 1, aggr 10, w2 2: hidden 4, out 80.
    send(fill_x(1), fill_w1(1), fill_w2(2), lat);
    chk("hid_latency", 128'(lat), 128'(3));
    for (int h = 0; h < N_HID; h++) chk("t1_hid", 128'(bus.hid_relu[h*HW +: HW]), 128'(4));
    drive_aggr(fill_a(10), 0);
    wait_out(1'b0, lat);
    chk("out_latency", 128'(lat), 128'(S2 + 1));
    for (int o = 0; o < N_OUT; o++)
      chk("t1_out", 128'(longint'($signed(bus.out_flat[o*OW +: OW]))), 128'(80));
    release_out(0);

    // Negative hidden sum -960 is clipped by ReLU.
    send(XF'(7'h40), fill_w1(15), W2F'(rnd128()), lat);
    for (int h = 0; h < N_HID; h++) chk("t2_relu", 128'(bus.hid_relu[h*HW +: HW]), 128'(0));
    drive_aggr(rand_aggr(), 1);
    wait_out(1'b0, lat);
    release_out(5);

    // Large negative layer-2 sum -4194240.
    send(XF'(rnd128()), W1F'(rnd128()), fill_w2(-16), lat);
    drive_aggr(fill_a(65535), 2);
    wait_out(1'b1, lat);
    for (int o = 0; o < N_OUT; o++)
`ifdef DNN_OUT_SAT_EN
      chk("t4_sat", 128'(longint'($signed(bus.out_flat[o*OW +: OW]))), 128'(-1048576));
`else
      chk("t4_wrap", 128'(longint'($signed(bus.out_flat[o*OW +: OW]))), 128'(64));
`endif
    release_out(0);

    // Reset during layer 2 aborts the sample.
    send(XF'(rnd128()), W1F'(rnd128()), W2F'(rnd128()), lat);
    drive_aggr(rand_aggr(), 0);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_flat", 128'(bus.out_flat), 128'(0));
    chk("rst_hid_relu", 128'(bus.hid_relu), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

    for (int n = 0; n < 40; n++) begin
      send(XF'(rnd128()), W1F'(rnd128()), W2F'(rnd128()), lat);
      drive_aggr(rand_aggr(), int'($urandom_range(0, 3)));
      wait_out(1'($urandom_range(0, 1)), lat);
      release_out(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
